// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS timeout enabled by defining APB_ARBITER_TIMEOUT_EN.
module apb_arbiter #(
    parameter int APB_AW  = 32,
    parameter int APB_DW  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [1:0]        i_req,
    input  logic [APB_AW-1:0] i_addr0,
    input  logic [APB_AW-1:0] i_addr1,
    input  logic [1:0]        i_write,
    input  logic [APB_DW-1:0] i_wdata0,
    input  logic [APB_DW-1:0] i_wdata1,
    output logic [1:0]        o_gnt,
    output logic [1:0]        o_done,
    output logic [APB_DW-1:0] o_rdata,
    output logic              o_err,
    output logic [APB_AW-1:0] o_PADDR,
    output logic              o_PWRITE,
    output logic [APB_DW-1:0] o_PWDATA,
    output logic              o_PSEL,
    output logic              o_PENABLE,
    input  logic [APB_DW-1:0] i_PRDATA,
    input  logic              i_PREADY,
    input  logic              i_PSLVERR
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("apb_arbiter: TIMEOUT must be >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t     r_state, w_next;
    logic       r_last;
    logic [1:0] w_elig;
    logic       w_win;
    logic       w_grant;
    logic       w_complete;
    logic       w_timeout;

    // A requester whose done pulse is showing sits out this arbitration round.
    assign w_elig = i_req & ~o_done;
    assign w_win  = (w_elig == 2'b11) ? ~r_last : w_elig[1];

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_tmo;

    assign w_timeout = (r_state == S_ACCESS) && !i_PREADY && (r_tmo == CW'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tmo <= '0;
        end else if (r_state == S_SETUP) begin
            r_tmo <= '0;
        end else if (r_state == S_ACCESS && !i_PREADY && !w_timeout) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        o_PSEL     = 1'b0;
        o_PENABLE  = 1'b0;
        w_grant    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_next  = S_SETUP;
                    w_grant = 1'b1;
                end
            end
            S_SETUP: begin
                o_PSEL = 1'b1;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                o_PSEL    = 1'b1;
                o_PENABLE = 1'b1;
                if (i_PREADY || w_timeout) begin
                    w_complete = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bus attributes are captured once at grant so requester input churn never reaches the bus.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_last   <= 1'b1;
            o_gnt    <= 2'b00;
            o_done   <= 2'b00;
            o_rdata  <= '0;
            o_err    <= 1'b0;
            o_PADDR  <= '0;
            o_PWRITE <= 1'b0;
            o_PWDATA <= '0;
        end else begin
            o_done <= 2'b00;
            if (w_grant) begin
                r_last   <= w_win;
                o_gnt    <= w_win ? 2'b10 : 2'b01;
                o_PADDR  <= w_win ? i_addr1 : i_addr0;
                o_PWRITE <= i_write[w_win];
                o_PWDATA <= w_win ? i_wdata1 : i_wdata0;
            end
            if (w_complete) begin
                o_gnt  <= 2'b00;
                o_done <= o_gnt;
                if (i_PREADY) begin
                    o_err   <= i_PSLVERR;
                    o_rdata <= o_PWRITE ? '0 : i_PRDATA;
                end else begin
                    o_err   <= 1'b1;
                    o_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed plus randomized bench for apb_arbiter against a transaction-timeline model.
module tb_apb_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 8;
    localparam int TMO = 16;
`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int STUCK_LEFT = 1 + TMO;
`else
    localparam int STUCK_LEFT = 1 << 30;
`endif

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b1;
    logic [1:0]    i_req = 2'b00;
    logic [1:0]    i_write = 2'b00;
    logic [AW-1:0] i_addr0 = '0, i_addr1 = '0;
    logic [DW-1:0] i_wdata0 = '0, i_wdata1 = '0, i_PRDATA = '0;
    logic          i_PREADY = 1'b0, i_PSLVERR = 1'b0;
    logic [1:0]    o_gnt, o_done;
    logic [DW-1:0] o_rdata, o_PWDATA;
    logic          o_err, o_PWRITE, o_PSEL, o_PENABLE;
    logic [AW-1:0] o_PADDR;

    apb_arbiter #(.APB_AW(AW), .APB_DW(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .i_req(i_req),
        .i_addr0(i_addr0), .i_addr1(i_addr1), .i_write(i_write),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
        .o_PADDR(o_PADDR), .o_PWRITE(o_PWRITE), .o_PWDATA(o_PWDATA),
        .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE),
        .i_PRDATA(i_PRDATA), .i_PREADY(i_PREADY), .i_PSLVERR(i_PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: a transfer occupies the bus for a known number of edges after its grant.
    bit            m_busy, m_setup;
    int            m_left;
    logic [1:0]    m_gnt, m_done;
    logic [DW-1:0] m_rdata, m_pwdata;
    logic [AW-1:0] m_paddr;
    logic          m_err, m_pwrite, m_last;

    int mode;       // 0: drop request on done, 1: re-request on done, 2: random
    int nxt_wait;
    bit stuck;
    bit rnd_slave;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_setup = 0; m_left = 0;
        m_gnt = 2'b00; m_done = 2'b00; m_rdata = '0; m_err = 1'b0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_last = 1'b1;
    endtask

    task automatic check_all();
        chk("gnt", 32'(o_gnt), 32'(m_gnt));
        chk("done", 32'(o_done), 32'(m_done));
        chk("psel", 32'(o_PSEL), 32'(m_busy));
        chk("penable", 32'(o_PENABLE), 32'(m_busy && !m_setup));
        chk("paddr", o_PADDR, m_paddr);
        chk("pwrite", 32'(o_PWRITE), 32'(m_pwrite));
        chk("pwdata", 32'(o_PWDATA), 32'(m_pwdata));
        if (m_done != 2'b00) begin
            chk("rdata", 32'(o_rdata), 32'(m_rdata));
            chk("err", 32'(o_err), 32'(m_err));
        end
    endtask

    task automatic new_attr(input int n);
        if (n == 0) begin
            i_addr0 = AW'($urandom); i_write[0] = 1'($urandom_range(0, 1)); i_wdata0 = DW'($urandom);
        end else begin
            i_addr1 = AW'($urandom); i_write[1] = 1'($urandom_range(0, 1)); i_wdata1 = DW'($urandom);
        end
    endtask

    task automatic advance();
        logic [1:0] elig, nd;
        logic       win;
        int         w;
        for (int n = 0; n < 2; n++) begin
            if (m_done[n]) begin
                if (mode == 0) i_req[n] = 1'b0;
                else if (mode == 1) new_attr(n);
                else begin
                    new_attr(n);
                    i_req[n] = 1'($urandom_range(0, 1));
                end
            end else if (mode == 2 && !i_req[n]) begin
                new_attr(n);
                if ($urandom_range(0, 2) == 0) i_req[n] = 1'b1;
            end
        end
        if (rnd_slave) begin
            i_PRDATA  = DW'($urandom);
            i_PSLVERR = 1'($urandom_range(0, 1));
        end
        i_PREADY = m_busy && !stuck && (m_left == 1);
        nd = 2'b00;
        if (m_busy) begin
            if (m_left == 1) begin
                nd      = m_gnt;
                m_err   = stuck ? 1'b1 : i_PSLVERR;
                m_rdata = (stuck || m_pwrite) ? '0 : i_PRDATA;
                m_gnt   = 2'b00;
                m_busy  = 0;
            end else begin
                m_left--;
            end
            m_setup = 0;
        end else begin
            elig = i_req & ~m_done;
            if (elig != 2'b00) begin
                win      = (elig == 2'b11) ? ~m_last : elig[1];
                m_last   = win;
                m_gnt    = win ? 2'b10 : 2'b01;
                m_paddr  = win ? i_addr1 : i_addr0;
                m_pwrite = i_write[win];
                m_pwdata = win ? i_wdata1 : i_wdata0;
                w        = (mode == 2) ? $urandom_range(0, 3) : nxt_wait;
                m_busy   = 1;
                m_setup  = 1;
                m_left   = stuck ? STUCK_LEFT : 2 + w;
            end
        end
        m_done = nd;
        @(posedge PCLK);
        @(negedge PCLK);
        check_all();
    endtask

    task automatic do_reset();
        PRESETn  = 1'b0;
        i_req    = 2'b00;
        i_PREADY = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt", 32'(o_gnt), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_rdata", 32'(o_rdata), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_paddr", o_PADDR, 0);
        chk("rst_pwrite", 32'(o_PWRITE), 0);
        chk("rst_pwdata", 32'(o_PWDATA), 0);
        chk("rst_psel", 32'(o_PSEL), 0);
        chk("rst_penable", 32'(o_PENABLE), 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    initial begin
        logic [1:0] gnt_log[$];
        logic [1:0] prev_gnt;
        logic [1:0] exp_ord[4];
        int         cnt;
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
        mode = 0; nxt_wait = 0; stuck = 0; rnd_slave = 0;
        #2;
        do_reset();

        // Single write from requester 0, no wait states.
        i_addr0 = 32'h10; i_wdata0 = 8'hA5; i_write = 2'b01; i_PRDATA = 8'h77; i_PSLVERR = 1'b0;
        i_req = 2'b01;
        advance();
        chk("a_setup_paddr", o_PADDR, 32'h10);
        chk("a_setup_pwdata", 32'(o_PWDATA), 32'hA5);
        advance();
        chk("a_access_pen", 32'(o_PENABLE), 1);
        advance();
        chk("a_done", 32'(o_done), 32'h1);
        chk("a_err", 32'(o_err), 0);
        advance(); advance();

        // Both requesters held from reset: strict alternation.
        do_reset();
        mode = 1; new_attr(0); new_attr(1);
        i_req = 2'b11; prev_gnt = 2'b00;
        for (int k = 0; k < 40 && gnt_log.size() < 4; k++) begin
            advance();
            if (o_gnt != 2'b00 && o_gnt !== prev_gnt) gnt_log.push_back(o_gnt);
            prev_gnt = o_gnt;
        end
        chk("b_order_len", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("b_order", 32'(gnt_log[i]), 32'(exp_ord[i]));
        mode = 0;
        for (int k = 0; k < 12; k++) advance();

        // Requester 1 read with three wait states.
        i_addr1 = 32'h0000_0200; i_write = 2'b00; i_PRDATA = 8'h3C; nxt_wait = 3;
        i_req = 2'b10;
        for (int k = 0; k < 12 && m_done == 2'b00; k++) advance();
        chk("c_done", 32'(o_done), 32'h2);
        chk("c_rdata", 32'(o_rdata), 32'h3C);
        advance();

        // Slave error on a write.
        i_PSLVERR = 1'b1; i_write = 2'b01; i_addr0 = 32'h44; nxt_wait = 0;
        i_req = 2'b01;
        for (int k = 0; k < 8 && m_done == 2'b00; k++) advance();
        chk("d_done", 32'(o_done), 32'h1);
        chk("d_err", 32'(o_err), 1);
        i_PSLVERR = 1'b0;
        advance();

        // Request withdrawn mid-transfer still completes.
        i_write = 2'b00; nxt_wait = 2; i_req = 2'b01;
        advance();
        i_req = 2'b00;
        for (int k = 0; k < 8 && m_done == 2'b00; k++) advance();
        chk("e_done", 32'(o_done), 32'h1);
        advance();

        // Slave never ready.
        stuck = 1; i_req = 2'b10; cnt = 0;
`ifdef APB_ARBITER_TIMEOUT_EN
        for (int k = 0; k < TMO + 8 && m_done == 2'b00; k++) begin
            advance();
            if (o_PENABLE === 1'b1) cnt++;
        end
        chk("f_done", 32'(o_done), 32'h2);
        chk("f_err", 32'(o_err), 1);
        chk("f_rdata", 32'(o_rdata), 0);
        chk("f_access_cycles", cnt, TMO);
        stuck = 0;
        advance();
`else
        for (int k = 0; k < 100; k++) begin
            advance();
            if (o_done !== 2'b00) cnt++;
        end
        chk("f_no_done", cnt, 0);
        stuck = 0;
        do_reset();
`endif

        // Reset during ACCESS, then a fresh transfer.
        i_write = 2'b01; i_addr0 = 32'h88; nxt_wait = 3; i_req = 2'b01;
        advance(); advance();
        chk("g_in_access", 32'(o_PENABLE), 1);
        do_reset();
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            advance();
            if (o_done !== 2'b00) cnt++;
        end
        chk("g_no_done", cnt, 0);
        i_write = 2'b00; i_addr1 = 32'h99; i_PRDATA = 8'h5A; nxt_wait = 0; i_req = 2'b10;
        for (int k = 0; k < 8 && m_done == 2'b00; k++) advance();
        chk("g_done", 32'(o_done), 32'h2);
        chk("g_rdata", 32'(o_rdata), 32'h5A);

        // Random traffic.
        mode = 2; rnd_slave = 1;
        for (int k = 0; k < 600; k++) advance();
        mode = 0;
        for (int k = 0; k < 20; k++) advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
